// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory port arbiter
package dmem_arb_pkg;

    localparam int   DMEM_XLEN = 32;
    localparam logic LANE1     = 1'b0;
    localparam logic LANE2     = 1'b1;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACC0, ARB_ACC1, ARB_DONE} arb_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 lane;
        logic                 we;
        logic [DMEM_XLEN-1:0] addr;
        logic [DMEM_XLEN-1:0] wdata;
        logic [2:0]           size;
    } mem_slot_t;

endpackage

// File: rtl/dmem_order_sel.sv
// dmem_order_sel: orders the two lane requests by PC into first/second access slots
module dmem_order_sel
    import dmem_arb_pkg::*;
(
    input  logic                 v1,
    input  logic                 v2,
    input  logic                 we1,
    input  logic                 we2,
    input  logic [DMEM_XLEN-1:0] addr1,
    input  logic [DMEM_XLEN-1:0] addr2,
    input  logic [DMEM_XLEN-1:0] wdata1,
    input  logic [DMEM_XLEN-1:0] wdata2,
    input  logic [2:0]           size1,
    input  logic [2:0]           size2,
    input  logic [DMEM_XLEN-1:0] pc1,
    input  logic [DMEM_XLEN-1:0] pc2,
    output mem_slot_t            slot0,
    output mem_slot_t            slot1
);

    mem_slot_t s1;
    mem_slot_t s2;
    logic      lane2_first;

    always_comb begin
        s1 = '{valid: v1, lane: LANE1, we: we1, addr: addr1, wdata: wdata1, size: size1};
        s2 = '{valid: v2, lane: LANE2, we: we2, addr: addr2, wdata: wdata2, size: size2};
        // equal PCs keep lane 1 first; a lone request always lands in slot0
        lane2_first = v2 && (!v1 || (pc2 < pc1));
        slot0 = lane2_first ? s2 : s1;
        slot1 = lane2_first ? s1 : s2;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises the two M-stage memory accesses onto one port, stalling the pipeline meanwhile
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int XLEN     = DMEM_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ReqM1,
    input  logic            ReqM2,
    input  logic            WeM1,
    input  logic            WeM2,
    input  logic [XLEN-1:0] AddrM1,
    input  logic [XLEN-1:0] AddrM2,
    input  logic [XLEN-1:0] WDataM1,
    input  logic [XLEN-1:0] WDataM2,
    input  logic [2:0]      SizeM1,
    input  logic [2:0]      SizeM2,
    input  logic [XLEN-1:0] PCM1,
    input  logic [XLEN-1:0] PCM2,
    input  logic            FlushM1,
    input  logic            FlushM2,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_size,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] RDataM1,
    output logic [XLEN-1:0] RDataM2,
    output logic            StallAll,
    output logic            MemErr
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    arb_state_t state, state_nxt;
    mem_slot_t  sel0, sel1, slot0, slot1, cur;
    logic [7:0] wait_cnt;
    logic       any_req, acc, timeout;

    dmem_order_sel u_order (
        .v1    (ReqM1 & ~FlushM1),
        .v2    (ReqM2 & ~FlushM2),
        .we1   (WeM1),
        .we2   (WeM2),
        .addr1 (AddrM1),
        .addr2 (AddrM2),
        .wdata1(WDataM1),
        .wdata2(WDataM2),
        .size1 (SizeM1),
        .size2 (SizeM2),
        .pc1   (PCM1),
        .pc2   (PCM2),
        .slot0 (sel0),
        .slot1 (sel1)
    );

    assign any_req = sel0.valid;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        cur       = (state == ARB_ACC1) ? slot1 : slot0;
        acc       = (state == ARB_ACC0) || (state == ARB_ACC1);
        timeout   = acc && !mem_ready && (wait_cnt == WAIT_LAST);
        mem_req   = acc && cur.valid;
        // the idle-cycle stall is combinational so the pipeline freezes before it advances
        StallAll  = acc || ((state == ARB_IDLE) && any_req && !rst);
        case (state)
            ARB_IDLE: state_nxt = any_req ? ARB_ACC0 : ARB_IDLE;
            ARB_ACC0:
                if (mem_ready)    state_nxt = slot1.valid ? ARB_ACC1 : ARB_DONE;
                else if (timeout) state_nxt = ARB_DONE;
            ARB_ACC1: if (mem_ready || timeout) state_nxt = ARB_DONE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    assign mem_we    = mem_req & cur.we;
    assign mem_addr  = mem_req ? cur.addr  : '0;
    assign mem_wdata = mem_req ? cur.wdata : '0;
    assign mem_size  = mem_req ? cur.size  : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0    <= '0;
            slot1    <= '0;
            wait_cnt <= '0;
            RDataM1  <= '0;
            RDataM2  <= '0;
            MemErr   <= 1'b0;
        end else begin
            if ((state == ARB_IDLE) && any_req) begin
                slot0 <= sel0;
                slot1 <= sel1;
            end
            if (acc) begin
                wait_cnt <= (mem_ready || timeout) ? '0 : wait_cnt + 8'd1;
                if (timeout) MemErr <= 1'b1;
                if (mem_ready && !cur.we && (cur.lane == LANE1)) RDataM1 <= mem_rdata;
                if (mem_ready && !cur.we && (cur.lane == LANE2)) RDataM2 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed and randomized checks of the arbiter against a transaction-level model
module tb_dmem_port_arbiter;

    localparam int MAXW = 4;

    logic        clk, rst;
    logic        ReqM1, ReqM2, WeM1, WeM2, FlushM1, FlushM2;
    logic [31:0] AddrM1, AddrM2, WDataM1, WDataM2, PCM1, PCM2;
    logic [2:0]  SizeM1, SizeM2;
    logic        mem_req, mem_we, mem_ready, StallAll, MemErr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, RDataM1, RDataM2;
    logic [2:0]  mem_size;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_r1, exp_r2;
    logic        exp_err;
    int          checks, failures;

    dmem_port_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .ReqM1(ReqM1), .ReqM2(ReqM2), .WeM1(WeM1), .WeM2(WeM2),
        .AddrM1(AddrM1), .AddrM2(AddrM2), .WDataM1(WDataM1), .WDataM2(WDataM2),
        .SizeM1(SizeM1), .SizeM2(SizeM2), .PCM1(PCM1), .PCM2(PCM2),
        .FlushM1(FlushM1), .FlushM2(FlushM2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .RDataM1(RDataM1), .RDataM2(RDataM2), .StallAll(StallAll), .MemErr(MemErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a, input bit use_ref);
        if (use_ref) return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic int rand_lat();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAXW, MAXW + 2)) : int'($urandom_range(0, MAXW - 1));
    endfunction

    // Starts one cycle after a rising edge with the arbiter idle; ends the same way.
    task automatic run_txn(
        input logic r1, input logic we1, input logic f1, input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] pc1,
        input logic r2, input logic we2, input logic f2, input logic [31:0] a2, input logic [31:0] d2, input logic [31:0] pc2,
        input int lat0, input int lat1);
        int          ord[$];
        logic [31:0] q_addr[$], q_data[$];
        logic        q_we[$];
        logic [2:0]  q_size[$];
        logic [2:0]  s1, s2;
        int          exp_cyc, exp_n, cyc, seen, idx, wc, lat_k;
        bit          fin;
        s1 = 3'($urandom_range(0, 7));
        s2 = 3'($urandom_range(0, 7));
        ReqM1 = r1; WeM1 = we1; FlushM1 = f1; AddrM1 = a1; WDataM1 = d1; PCM1 = pc1; SizeM1 = s1;
        ReqM2 = r2; WeM2 = we2; FlushM2 = f2; AddrM2 = a2; WDataM2 = d2; PCM2 = pc2; SizeM2 = s2;
        mem_ready = 1'b0;
        if ((r1 && !f1) && (r2 && !f2)) begin
            if (pc2 < pc1) begin ord.push_back(2); ord.push_back(1); end
            else begin ord.push_back(1); ord.push_back(2); end
        end else if (r1 && !f1) ord.push_back(1);
        else if (r2 && !f2) ord.push_back(2);
        exp_cyc = (ord.size() != 0) ? 1 : 0;
        exp_n = 0;
        foreach (ord[k]) begin
            lat_k = (k == 0) ? lat0 : lat1;
            q_addr.push_back(ord[k] == 1 ? a1 : a2);
            q_data.push_back(ord[k] == 1 ? d1 : d2);
            q_we.push_back(ord[k] == 1 ? we1 : we2);
            q_size.push_back(ord[k] == 1 ? s1 : s2);
            exp_n++;
            if (lat_k >= MAXW) begin
                exp_err = 1'b1;
                exp_cyc += MAXW;
                break;
            end
            exp_cyc += lat_k + 1;
            if (q_we[k]) ref_mem[q_addr[k]] = q_data[k];
            else if (ord[k] == 1) exp_r1 = rd(q_addr[k], 1);
            else exp_r2 = rd(q_addr[k], 1);
        end
        #4;
        chk("idle_stall", {31'b0, StallAll}, {31'b0, ord.size() != 0});
        cyc = (ord.size() != 0) ? 1 : 0;
        seen = 0; idx = 0; wc = 0; fin = 0;
        for (int t = 0; t < 40 && !fin; t++) begin
            @(posedge clk);
            #1;
            if (!mem_req) begin
                fin = 1;
                mem_ready = 1'b0;
            end else begin
                cyc++;
                chk("acc_stall", {31'b0, StallAll}, 32'd1);
                if (wc == 0) begin
                    seen++;
                    if (idx < q_addr.size()) begin
                        chk("acc_addr", mem_addr, q_addr[idx]);
                        chk("acc_we", {31'b0, mem_we}, {31'b0, q_we[idx]});
                        chk("acc_size", {29'b0, mem_size}, {29'b0, q_size[idx]});
                        if (q_we[idx]) chk("acc_wdata", mem_wdata, q_data[idx]);
                    end
                end
                lat_k = (idx == 0) ? lat0 : lat1;
                if (wc == lat_k) begin
                    mem_ready = 1'b1;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else mem_rdata = rd(mem_addr, 0);
                    idx++;
                    wc = 0;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                    wc++;
                end
            end
        end
        chk("txn_finished", {31'b0, fin}, 32'd1);
        chk("done_stall", {31'b0, StallAll}, 32'd0);
        chk("stall_cycles", cyc, exp_cyc);
        chk("access_count", seen, exp_n);
        chk("rdata1", RDataM1, exp_r1);
        chk("rdata2", RDataM2, exp_r2);
        chk("memerr", {31'b0, MemErr}, {31'b0, exp_err});
        ReqM1 = 1'b0;
        ReqM2 = 1'b0;
        @(posedge clk);
        #1;
        chk("back_idle", {30'b0, StallAll, mem_req}, 32'd0);
    endtask

    initial begin
        checks = 0; failures = 0;
        exp_r1 = '0; exp_r2 = '0; exp_err = 1'b0;
        ReqM1 = 0; ReqM2 = 0; WeM1 = 0; WeM2 = 0; FlushM1 = 0; FlushM2 = 0;
        AddrM1 = 0; AddrM2 = 0; WDataM1 = 0; WDataM2 = 0; PCM1 = 0; PCM2 = 0;
        SizeM1 = 0; SizeM2 = 0; mem_ready = 0; mem_rdata = 0;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[32'h100 + 32'(4 * i)] = v;
            ref_mem[32'h100 + 32'(4 * i)] = v;
        end
        mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        rst = 1'b1;
        #3;
        chk("rst_stall", {31'b0, StallAll}, 32'd0);
        chk("rst_memreq", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_rdata1", RDataM1, 32'd0);
        chk("rst_rdata2", RDataM2, 32'd0);
        chk("rst_memerr", {31'b0, MemErr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single lane-1 load with immediate ready
        run_txn(1, 0, 0, 32'h100, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0);
        // both loads, lane 2 older
        run_txn(1, 0, 0, 32'h104, 0, 32'h40, 1, 0, 0, 32'h108, 0, 32'h3C, 0, 0);
        // older store then younger load to the same address
        run_txn(1, 1, 0, 32'h200, 32'h55, 32'h10, 1, 0, 0, 32'h200, 0, 32'h14, 0, 0);
        // flushed lane 2 is ignored
        run_txn(1, 0, 0, 32'h10C, 0, 32'h30, 1, 0, 1, 32'h110, 0, 32'h2C, 0, 0);
        // memory never answers: abort, sticky error
        run_txn(1, 0, 0, 32'h114, 0, 32'h50, 0, 0, 0, 0, 0, 0, 100, 0);
        run_txn(0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h118, 0, 32'h54, 2, 0);

        // reset asserted while the second access waits
        ReqM1 = 1; WeM1 = 0; FlushM1 = 0; AddrM1 = 32'h104; PCM1 = 32'h10;
        ReqM2 = 1; WeM2 = 0; FlushM2 = 0; AddrM2 = 32'h108; PCM2 = 32'h14;
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = 32'h1234;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("t6_acc1_addr", mem_addr, 32'h108);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_stall", {31'b0, StallAll}, 32'd0);
        chk("t6_memreq", {31'b0, mem_req}, 32'd0);
        chk("t6_addr", mem_addr, 32'd0);
        chk("t6_rdata1", RDataM1, 32'd0);
        chk("t6_memerr", {31'b0, MemErr}, 32'd0);
        ReqM1 = 0; ReqM2 = 0;
        exp_r1 = '0; exp_r2 = '0; exp_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_idle", {30'b0, StallAll, mem_req}, 32'd0);

        for (int n = 0; n < 40; n++) begin
            run_txn($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
                    32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom, 32'h10 + 32'(4 * $urandom_range(0, 3)),
                    $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
                    32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom, 32'h10 + 32'(4 * $urandom_range(0, 3)),
                    rand_lat(), rand_lat());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
